// File: rtl/me_multi_dispatch.sv
// Tagged job scheduler for a bank of modexp cores. It queues jobs, starts each on the lowest idle
// core, and returns results in completion order through one round-robin output register.
module me_multi_dispatch #(
    parameter int unsigned M_SIZE     = 3072,
    parameter int unsigned NUM_CORE   = 4,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [TAG_W-1:0]             req_tag,
    input  logic [M_SIZE-1:0]            req_a,
    input  logic [M_SIZE-1:0]            req_e,
    output logic [NUM_CORE-1:0]          core_en,
    output logic [M_SIZE-1:0]            core_a,
    output logic [M_SIZE-1:0]            core_e,
    output logic [TAG_W-1:0]             core_tag,
    input  logic [NUM_CORE-1:0]          core_done,
    input  logic [NUM_CORE*M_SIZE-1:0]   core_z,
    input  logic [NUM_CORE*TAG_W-1:0]    core_num_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [M_SIZE-1:0]            res_z,
    output logic [TAG_W-1:0]             res_tag,
    output logic [NUM_CORE-1:0]          core_busy,
    output logic                         err_tag,
    output logic                         err_spurious
);

    localparam int unsigned CW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
    localparam logic [FIFO_AW:0] FifoFull = FIFO_DEPTH[FIFO_AW:0];

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    logic [M_SIZE-1:0]  fifo_a_q   [FIFO_DEPTH];
    logic [M_SIZE-1:0]  fifo_e_q   [FIFO_DEPTH];
    logic [TAG_W-1:0]   fifo_tag_q [FIFO_DEPTH];
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               req_ready_q, fifo_empty, push, pop;
    logic [FIFO_AW-1:0] rd_idx;

    logic [1:0]         slot_state_q [NUM_CORE];
    logic [1:0]         slot_state_d [NUM_CORE];
    logic [TAG_W-1:0]   slot_tag_q   [NUM_CORE];
    logic [M_SIZE-1:0]  slot_z_q     [NUM_CORE];

    logic               any_idle, grant_valid, grant_take, load_out;
    logic [CW-1:0]      idle_idx, grant_idx, cand, last_grant_q;
    logic [NUM_CORE-1:0] core_en_q;
    logic [M_SIZE-1:0]  core_a_q, core_e_q, res_z_q;
    logic [TAG_W-1:0]   core_tag_q, res_tag_q;
    logic               res_valid_q, err_tag_q, err_tag_d, err_spur_q, err_spur_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign rd_idx     = rd_ptr_q[FIFO_AW-1:0];
    assign push       = req_valid && req_ready_q;
    assign pop        = !fifo_empty && any_idle;
    assign wr_ptr_d   = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
    assign rd_ptr_d   = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
    assign load_out   = !res_valid_q || res_ready;
    assign grant_take = load_out && grant_valid;

    always_comb begin
        any_idle = 1'b0;
        idle_idx = '0;
        for (int i = 0; i < int'(NUM_CORE); i++) begin
            if (!any_idle && slot_state_q[i] == StIdle) begin
                any_idle = 1'b1;
                idle_idx = CW'(i);
            end
        end
    end

    // Round-robin search over HOLD slots, starting just after the last slot served.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < int'(NUM_CORE); k++) begin
            cand = CW'((int'(last_grant_q) + 1 + k) % int'(NUM_CORE));
            if (!grant_valid && slot_state_q[cand] == StHold) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        err_tag_d  = err_tag_q;
        err_spur_d = err_spur_q;
        for (int i = 0; i < int'(NUM_CORE); i++) begin
            slot_state_d[i] = slot_state_q[i];
            case (slot_state_q[i])
                StIdle: if (pop && idle_idx == CW'(i)) slot_state_d[i] = StRun;
                StRun: begin
                    if (core_done[i]) begin
                        slot_state_d[i] = StHold;
                        if (core_num_out[i*TAG_W +: TAG_W] != slot_tag_q[i]) err_tag_d = 1'b1;
                    end
                end
                StHold: if (grant_take && grant_idx == CW'(i)) slot_state_d[i] = StIdle;
                default: slot_state_d[i] = StIdle;
            endcase
            if (core_done[i] && slot_state_q[i] != StRun) err_spur_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            req_ready_q  <= 1'b1;
            // Start the round-robin pointer so slot 0 is searched first.
            last_grant_q <= CW'(NUM_CORE - 1);
            core_en_q    <= '0;
            core_a_q     <= '0;
            core_e_q     <= '0;
            core_tag_q   <= '0;
            res_valid_q  <= 1'b0;
            res_z_q      <= '0;
            res_tag_q    <= '0;
            err_tag_q    <= 1'b0;
            err_spur_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_CORE); i++) slot_state_q[i] <= StIdle;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            req_ready_q <= ((wr_ptr_d - rd_ptr_d) != FifoFull);
            err_tag_q   <= err_tag_d;
            err_spur_q  <= err_spur_d;
            for (int i = 0; i < int'(NUM_CORE); i++) slot_state_q[i] <= slot_state_d[i];
            core_en_q <= '0;
            if (pop) begin
                core_en_q[idle_idx] <= 1'b1;
                core_a_q            <= fifo_a_q[rd_idx];
                core_e_q            <= fifo_e_q[rd_idx];
                core_tag_q          <= fifo_tag_q[rd_idx];
            end
            if (grant_take) begin
                res_valid_q  <= 1'b1;
                res_z_q      <= slot_z_q[grant_idx];
                res_tag_q    <= slot_tag_q[grant_idx];
                last_grant_q <= grant_idx;
            end else if (load_out) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    // Payload storage carries no reset; its validity is tracked by pointers and slot states.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q[FIFO_AW-1:0]]   <= req_a;
            fifo_e_q[wr_ptr_q[FIFO_AW-1:0]]   <= req_e;
            fifo_tag_q[wr_ptr_q[FIFO_AW-1:0]] <= req_tag;
        end
        for (int i = 0; i < int'(NUM_CORE); i++) begin
            if (pop && idle_idx == CW'(i)) slot_tag_q[i] <= fifo_tag_q[rd_idx];
            if (slot_state_q[i] == StRun && core_done[i]) slot_z_q[i] <= core_z[i*M_SIZE +: M_SIZE];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CORE); i++) core_busy[i] = (slot_state_q[i] != StIdle);
    end

    assign req_ready    = req_ready_q;
    assign core_en      = core_en_q;
    assign core_a       = core_a_q;
    assign core_e       = core_e_q;
    assign core_tag     = core_tag_q;
    assign res_valid    = res_valid_q;
    assign res_z        = res_z_q;
    assign res_tag      = res_tag_q;
    assign err_tag      = err_tag_q;
    assign err_spurious = err_spur_q;

endmodule

// File: tb/tb_me_multi_dispatch.sv
// Scoreboard bench for me_multi_dispatch with two behavioural modexp cores (mod 0xD3C1).
module tb_me_multi_dispatch;

    localparam int M = 16;
    localparam int NC = 2;
    localparam int TW = 4;
    localparam logic [15:0] MODV = 16'hD3C1;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [M-1:0]  z;
    } exp_t;

    logic clk, rst_n, req_valid, req_ready, res_valid, res_ready, err_tag, err_spurious;
    logic [TW-1:0] req_tag, core_tag, res_tag;
    logic [M-1:0] req_a, req_e, core_a, core_e, res_z;
    logic [NC-1:0] core_en, core_done, core_busy;
    logic [NC*M-1:0] core_z;
    logic [NC*TW-1:0] core_num_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    exp_t sb[$];
    logic [TW-1:0] obs_tag[$];
    int obs_cyc[$];

    // Core models
    int unsigned dly [NC];
    int cnt [NC];
    logic [NC-1:0] go, spur, xor_tag, mrun, mdone, first_set;
    logic [M-1:0] mz [NC];
    logic [TW-1:0] mnum [NC];
    logic [TW-1:0] first_tag [NC];

    me_multi_dispatch #(
        .M_SIZE(M), .NUM_CORE(NC), .TAG_W(TW), .FIFO_DEPTH(4), .FIFO_AW(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_a(req_a), .req_e(req_e), .core_en(core_en),
        .core_a(core_a), .core_e(core_e), .core_tag(core_tag), .core_done(core_done),
        .core_z(core_z), .core_num_out(core_num_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_z(res_z), .res_tag(res_tag), .core_busy(core_busy),
        .err_tag(err_tag), .err_spurious(err_spurious)
    );

    function automatic logic [M-1:0] modexp(input logic [M-1:0] a, input logic [M-1:0] e);
        longint unsigned r, b;
        r = 1;
        b = longint'(a) % longint'(MODV);
        for (int i = 0; i < M; i++) begin
            if (e[i]) r = (r * b) % longint'(MODV);
            b = (b * b) % longint'(MODV);
        end
        return r[M-1:0];
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (!rst_n) begin
                mrun[i] <= 1'b0;
                mdone[i] <= 1'b0;
                first_set[i] <= 1'b0;
                mz[i] <= '0;
                mnum[i] <= '0;
            end else begin
                mdone[i] <= 1'b0;
                if (core_en[i]) begin
                    mrun[i] <= 1'b1;
                    cnt[i] <= int'(dly[i]);
                    mz[i] <= modexp(core_a, core_e);
                    mnum[i] <= core_tag ^ {3'b000, xor_tag[i]};
                    if (!first_set[i]) begin
                        first_set[i] <= 1'b1;
                        first_tag[i] <= core_tag;
                    end
                end else if (mrun[i]) begin
                    if (cnt[i] <= 1 || go[i]) begin
                        mdone[i] <= 1'b1;
                        mrun[i] <= 1'b0;
                    end else begin
                        cnt[i] <= cnt[i] - 1;
                    end
                end
            end
        end
    end

    assign core_done = mdone | spur;
    assign core_z = {mz[1], mz[0]};
    assign core_num_out = {mnum[1], mnum[0]};

    // Scoreboard: expected results enter on accepted requests and leave on accepted results.
    always @(negedge clk) begin
        int idx;
        exp_t ent;
        if (rst_n && req_valid && req_ready) begin
            ent.tag = req_tag;
            ent.z = modexp(req_a, req_e);
            sb.push_back(ent);
        end
        if (rst_n && res_valid && res_ready) begin
            n_vec++;
            idx = -1;
            foreach (sb[k]) if (idx < 0 && sb[k].tag == res_tag) idx = k;
            if (idx < 0) begin
                n_err++;
                $display("FAIL result_unexpected tag=%0d z=%h (no such job outstanding)", res_tag,
                         res_z);
            end else begin
                if (res_z !== sb[idx].z) begin
                    n_err++;
                    $display("FAIL result_z tag=%0d got=%h exp=%h", res_tag, res_z, sb[idx].z);
                end
                sb.delete(idx);
            end
            obs_tag.push_back(res_tag);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b0;
        go = '0;
        spur = '0;
        xor_tag = '0;
        tick(2);
        rst_n = 1'b1;
        sb.delete();
        obs_tag.delete();
        obs_cyc.delete();
    endtask

    task automatic push_job(input logic [TW-1:0] t, input logic [M-1:0] a, input logic [M-1:0] e);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_tag = t;
        req_a = a;
        req_e = e;
        for (int w = 0; w < 300 && !ok; w++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout tag=%0d got=not accepted exp=accepted", t);
        end
    endtask

    task automatic wait_results(input int n, input int budget, input string name);
        int w;
        w = 0;
        while (obs_tag.size() < n && w < budget) begin
            tick(1);
            w++;
        end
        n_vec++;
        if (obs_tag.size() < n) begin
            n_err++;
            $display("FAIL %s_timeout got=%0d results exp=%0d", name, obs_tag.size(), n);
        end
    endtask

    task automatic fire(input logic [NC-1:0] mask);
        go = mask;
        tick(1);
        go = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready);
        end
        n_vec++;
        if ({res_valid, core_en, core_busy, err_tag, err_spurious} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags got=%b exp=0",
                     {res_valid, core_en, core_busy, err_tag, err_spurious});
        end
        n_vec++;
        if ({core_a, core_e, core_tag, res_z, res_tag} !== '0) begin
            n_err++; $display("FAIL reset_buses got=%h exp=0", {core_a, core_e, core_tag, res_z, res_tag});
        end
    endtask

    task automatic test_single();
        do_reset();
        dly[0] = 3; dly[1] = 3;
        res_ready = 1'b1;
        push_job(4'd5, 16'h5537, 16'h0007);
        n_vec++;
        if (core_en !== 2'b00) begin n_err++; $display("FAIL t1_en_early got=%b exp=00", core_en); end
        tick(1);
        n_vec++;
        if (core_en !== 2'b01) begin n_err++; $display("FAIL t1_en_pulse got=%b exp=01", core_en); end
        tick(1);
        n_vec++;
        if (core_en !== 2'b00 || core_busy !== 2'b01) begin
            n_err++; $display("FAIL t1_en_busy got=%b/%b exp=00/01", core_en, core_busy);
        end
        wait_results(1, 50, "t1");
        n_vec++;
        if (obs_tag.size() != 1 || obs_tag[0] !== 4'd5) begin
            n_err++; $display("FAIL t1_tag got=%p exp=5", obs_tag);
        end
        n_vec++;
        if (res_valid !== 1'b0 || core_busy !== 2'b00) begin
            n_err++; $display("FAIL t1_idle got=%b/%b exp=0/00", res_valid, core_busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        dly[0] = 50; dly[1] = 50;
        res_ready = 1'b1;
        for (int t = 1; t <= 6; t++) push_job(TW'(t), 16'(t * 16'h1357 + 3), 16'(t + 2));
        n_vec++;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL t2_full got=%b exp=0", req_ready); end
        wait_results(6, 500, "t2");
        tick(20);
        n_vec++;
        if (first_tag[0] !== 4'd1 || first_tag[1] !== 4'd2) begin
            n_err++; $display("FAIL t2_first got=%0d,%0d exp=1,2", first_tag[0], first_tag[1]);
        end
        n_vec++;
        if (obs_tag.size() != 6 || sb.size() != 0) begin
            n_err++; $display("FAIL t2_count got=%0d left=%0d exp=6/0", obs_tag.size(), sb.size());
        end
    endtask

    task automatic test_completion_order();
        do_reset();
        dly[0] = 40; dly[1] = 10;
        res_ready = 1'b1;
        push_job(4'd3, 16'h1234, 16'h0101);
        push_job(4'd4, 16'hBEEF, 16'h0033);
        wait_results(2, 200, "t3");
        n_vec++;
        if (obs_tag.size() != 2 || obs_tag[0] !== 4'd4 || obs_tag[1] !== 4'd3) begin
            n_err++; $display("FAIL t3_order got=%p exp=4,3", obs_tag);
        end
    endtask

    task automatic test_simultaneous_rr();
        do_reset();
        dly[0] = 1000; dly[1] = 1000;
        res_ready = 1'b0;
        for (int t = 10; t <= 14; t++) push_job(TW'(t), 16'(t * 16'h0F1D), 16'(t));
        tick(3);
        fire(2'b01);
        tick(8);
        fire(2'b11);
        tick(2);
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (core_busy !== 2'b11 || core_en !== 2'b00 || res_valid !== 1'b1 ||
                res_tag !== 4'd10 || req_ready !== 1'b1) begin
                n_err++;
                $display("FAIL t4_hold busy=%b en=%b vld=%b tag=%0d rdy=%b exp=11,00,1,10,1",
                         core_busy, core_en, res_valid, res_tag, req_ready);
            end
            tick(1);
        end
        res_ready = 1'b1;
        wait_results(3, 20, "t4a");
        n_vec++;
        if (obs_tag.size() < 3 || obs_tag[0] !== 4'd10 || obs_tag[1] !== 4'd11 ||
            obs_tag[2] !== 4'd12) begin
            n_err++; $display("FAIL t4_rr got=%p exp=10,11,12", obs_tag);
        end else begin
            n_vec++;
            if (obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[1] + 1) begin
                n_err++;
                $display("FAIL t4_b2b got=%0d,%0d,%0d exp=consecutive", obs_cyc[0], obs_cyc[1],
                         obs_cyc[2]);
            end
        end
        tick(8);
        fire(2'b11);
        wait_results(5, 40, "t4b");
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL t4_drain got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_errors();
        do_reset();
        dly[0] = 5; dly[1] = 5;
        res_ready = 1'b1;
        xor_tag = 2'b01;
        n_vec++;
        if (err_tag !== 1'b0) begin n_err++; $display("FAIL t5_err_tag0 got=%b exp=0", err_tag); end
        push_job(4'd6, 16'h0ACE, 16'h0013);
        wait_results(1, 50, "t5");
        n_vec++;
        if (err_tag !== 1'b1 || obs_tag.size() != 1 || obs_tag[0] !== 4'd6) begin
            n_err++; $display("FAIL t5_err_tag got=%b tags=%p exp=1,6", err_tag, obs_tag);
        end
        tick(5);
        n_vec++;
        if (err_tag !== 1'b1 || err_spurious !== 1'b0) begin
            n_err++; $display("FAIL t5_sticky got=%b/%b exp=1/0", err_tag, err_spurious);
        end
        spur = 2'b10;
        tick(1);
        spur = 2'b00;
        n_vec++;
        if (err_spurious !== 1'b1 || core_busy !== 2'b00) begin
            n_err++; $display("FAIL t5_spur got=%b/%b exp=1/00", err_spurious, core_busy);
        end
        xor_tag = 2'b00;
    endtask

    task automatic test_mid_reset();
        do_reset();
        dly[0] = 1000; dly[1] = 1000;
        res_ready = 1'b1;
        for (int t = 1; t <= 5; t++) push_job(TW'(t), 16'(t * 16'h2222), 16'(t + 5));
        tick(3);
        n_vec++;
        if (core_busy !== 2'b11) begin n_err++; $display("FAIL t6_busy got=%b exp=11", core_busy); end
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        sb.delete();
        n_vec++;
        if (res_valid !== 1'b0 || core_busy !== 2'b00 || req_ready !== 1'b1 || core_en !== 2'b00)
        begin
            n_err++;
            $display("FAIL t6_reset got=%b,%b,%b,%b exp=0,00,1,00", res_valid, core_busy,
                     req_ready, core_en);
        end
        fire(2'b11);
        tick(40);
        n_vec++;
        if (obs_tag.size() != 5 - 5 + 0 && obs_tag.size() != 0) begin
            n_err++; $display("FAIL t6_stale got=%0d results exp=0", obs_tag.size());
        end
        n_vec++;
        if (core_busy !== 2'b00 || res_valid !== 1'b0) begin
            n_err++; $display("FAIL t6_quiet got=%b/%b exp=00/0", core_busy, res_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_tag = '0;
        req_a = '0;
        req_e = '0;
        res_ready = 1'b0;
        go = '0;
        spur = '0;
        xor_tag = '0;
        dly[0] = 1; dly[1] = 1;
        test_reset();
        test_single();
        test_back_to_back();
        test_completion_order();
        test_simultaneous_rr();
        test_errors();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/me_multi_dispatch.md
Name: me_multi_dispatch

Overview:
- Tagged request scheduler in front of NUM_CORE modular-exponentiation cores (me_top-class engines with en_me / num / done / num_out).
- Buffers exponentiation jobs (base a, exponent e, tag) in a FIFO and issues each job to the lowest-index idle core.
- Captures each core's result and tag, then returns results in completion order over a valid/ready port using round-robin arbitration.
- m, m_n and m_prime are static and wired to the cores outside this block.

Parameters:
M_SIZE, 3072, operand/result width in bits
NUM_CORE, 4, number of attached ME cores (1..8)
TAG_W, 4, tag width (matches num/num_out)
FIFO_DEPTH, 4, request FIFO entries (power of 2)
FIFO_AW, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  job offered
req_ready  out  1  FIFO not full (registered)
req_tag  in  TAG_W  job tag
req_a  in  M_SIZE  base
req_e  in  M_SIZE  exponent
core_en  out  NUM_CORE  one-cycle start pulse, one-hot
core_a  out  M_SIZE  shared base bus to cores
core_e  out  M_SIZE  shared exponent bus to cores
core_tag  out  TAG_W  shared tag bus (drives core num)
core_done  in  NUM_CORE  per-core completion pulse
core_z  in  NUM_CORE*M_SIZE  per-core result; core i at [i*M_SIZE +: M_SIZE]
core_num_out  in  NUM_CORE*TAG_W  per-core returned tag
res_valid  out  1  result available
res_ready  in  1  result accepted
res_z  out  M_SIZE  result value
res_tag  out  TAG_W  result tag (tag as dispatched)
core_busy  out  NUM_CORE  core slot not IDLE
err_tag  out  1  sticky: core_num_out differed from dispatched tag
err_spurious  out  1  sticky: core_done seen while core not RUN

Behaviour:
- Reset (rst_n=0 at a clock edge): FIFO empty; all slots IDLE; every output 0 except req_ready=1. Reset mid-job discards all queued and in-flight work. Cores share rst_n.
- FIFO:
  - Push when req_valid && req_ready.
  - req_ready = !full, registered.
  - An entry pushed at cycle N is dispatchable at N+1 at the earliest; there is no bypass.
  - Pointers are FIFO_AW+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - Push and pop in the same cycle keep the count unchanged.
- Dispatch:
  - At most one job per cycle. If the FIFO is non-empty and any slot is IDLE, pop the head and select the lowest-index IDLE slot i.
  - Next cycle: core_en[i]=1 for one cycle; core_a, core_e and core_tag are registered from the head. These buses hold until the next dispatch.
  - Slot i stores the tag and goes RUN in the same cycle core_en rises.
- Per-slot FSM (IDLE, RUN, HOLD):
  - IDLE->RUN on dispatch.
  - RUN->HOLD on core_done[i]. Capture core_z slice into the slot's result register. If core_num_out slice != stored tag, set err_tag; the stored tag is still returned.
  - HOLD->IDLE when the slot's result is loaded into the output register.
  - core_done[i] while IDLE or HOLD is ignored and sets err_spurious.
  - A slot is never re-dispatched before its result leaves, so results are never overwritten.
- Output stage:
  - A single register holds res_valid, res_z and res_tag.
  - It loads when empty, or when res_valid && res_ready in the same cycle (back-to-back: one result per cycle).
  - Source is the first HOLD slot in round-robin order starting at (last_grant+1) mod NUM_CORE.
  - res_valid/res_z/res_tag stay stable until accepted.
- Latency: core_done at cycle N -> slot HOLD at N+1 -> res_valid at N+2 minimum. req push at N -> core_en at N+2 minimum.
- core_busy[i] = (slot i != IDLE). Sticky error flags clear only on reset.
- Simultaneous events: core_done of several cores in one cycle are all captured. A dispatch and a HOLD->IDLE release in the same cycle are independent; the released slot is eligible the following cycle.

Test Plan:
- Bench uses M_SIZE=16, NUM_CORE=2, FIFO_DEPTH=4 with behavioural core models (z = a^e mod 0xD3C1, done after programmable delay, num_out=num).
  1. Single job (a=0x5537, e=0x0007, tag=5), res_ready=1 -> core_en=2'b01 two cycles after push; res_tag=5, res_z=golden, res_valid one cycle; core_busy returns to 0.
  2. Push 6 jobs back-to-back (tags 1..6), core delays 50 -> req_ready drops after FIFO fills (4 queued, 2 dispatched); tags 1,2 go to cores 0,1; all 6 results return, each tag exactly once.
  3. Core1 delay 10, core0 delay 40, tags 3 then 4 -> tag 4 (core1) returned before tag 3: completion order.
  4. Both cores done in the same cycle, res_ready=0 for 5 cycles -> both slots HOLD, no dispatch from a non-empty FIFO; on release, results alternate by round-robin in consecutive cycles.
  5. Core model returns num_out=tag^1 -> err_tag=1 and stays 1; result still delivered with the dispatched tag. Extra core_done pulse to an IDLE core -> err_spurious=1.
  6. rst_n=0 for one cycle while 2 jobs run and 3 are queued -> next cycle: res_valid=0, core_busy=0, req_ready=1; no stale result ever appears.
